// File: rtl/ctu60s.sv
// ctu60s: two-digit BCD seconds up-counter, 00 .. MODULUS-1.
// A qualified tick advances the count. When the count wraps back to 00,
// carry pulses high for one cycle; the minutes stage uses this pulse as
// its tick. A parallel BCD preset is range-checked, and an illegal preset
// sets the sticky load_err flag.
// Optional build macro CTU60S_TERMINAL_STOP_EN (stopwatch mode): a tick at
// MODULUS-1 freezes the count there and pulses carry once. The count then
// stays frozen until rst or a load (valid or invalid).
// MODULUS legal range is 2..100.
//
// state   | meaning
// running | count advances on qualified ticks
// stopped | (stopwatch mode only) parked at MODULUS-1, ticks ignored

module ctu60s #(
  parameter int unsigned MODULUS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_in,
  input  logic       cnt_en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] x,
  output logic       carry,
  output logic       load_err
);

  localparam int unsigned TERM     = MODULUS - 1;
  localparam logic [3:0]  TERM_H   = 4'(TERM / 10);
  localparam logic [3:0]  TERM_L   = 4'(TERM % 10);
  localparam logic [7:0]  TERM_DEC = 8'(TERM);

  logic [3:0] sec_h_q, sec_h_d;
  logic [3:0] sec_l_q, sec_l_d;
  logic       carry_q, carry_d;
  logic       load_err_q, load_err_d;

  logic [7:0] load_dec;
  logic       load_ok;
  logic       at_term;
  logic       tick;

`ifdef CTU60S_TERMINAL_STOP_EN
  logic stopped_q, stopped_d;
`endif

  // Preset validation and qualified tick decode.
  always_comb begin
    // The digits can reach 15*10+15 = 165 before validation, which still fits in 8 bits.
    load_dec = ({4'd0, load_val[7:4]} * 8'd10) + {4'd0, load_val[3:0]};
    load_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
               (load_dec <= TERM_DEC);
    at_term  = (sec_h_q == TERM_H) && (sec_l_q == TERM_L);
`ifdef CTU60S_TERMINAL_STOP_EN
    tick     = cnt_en && pulse_in && !stopped_q;
`else
    tick     = cnt_en && pulse_in;
`endif
  end

  // Next-state logic. Load takes priority over counting; otherwise the count holds.
  always_comb begin
    sec_h_d    = sec_h_q;
    sec_l_d    = sec_l_q;
    carry_d    = 1'b0;
    load_err_d = load_err_q;
`ifdef CTU60S_TERMINAL_STOP_EN
    stopped_d  = stopped_q;
`endif
    if (load) begin
      if (load_ok) begin
        sec_h_d    = load_val[7:4];
        sec_l_d    = load_val[3:0];
        load_err_d = 1'b0;
      end else begin
        sec_h_d    = 4'd0;
        sec_l_d    = 4'd0;
        load_err_d = 1'b1;
      end
`ifdef CTU60S_TERMINAL_STOP_EN
      stopped_d  = 1'b0;
`endif
    end else if (tick) begin
      if (at_term) begin
        carry_d = 1'b1;
`ifdef CTU60S_TERMINAL_STOP_EN
        stopped_d = 1'b1;
`else
        sec_h_d = 4'd0;
        sec_l_d = 4'd0;
`endif
      end else if (sec_l_q == 4'd9) begin
        sec_l_d = 4'd0;
        sec_h_d = sec_h_q + 4'd1;
      end else begin
        sec_l_d = sec_l_q + 4'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_h_q    <= 4'd0;
      sec_l_q    <= 4'd0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sec_h_q    <= sec_h_d;
      sec_l_q    <= sec_l_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

`ifdef CTU60S_TERMINAL_STOP_EN
  // Stopwatch park flag.
  always_ff @(posedge clk) begin
    if (rst) stopped_q <= 1'b0;
    else     stopped_q <= stopped_d;
  end
`endif

  assign x        = {sec_h_q, sec_l_q};
  assign carry    = carry_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_ctu60s.sv
// Bench for ctu60s: directed vector table plus hand sequences for wrap,
// MODULUS=24 and MODULUS=100 corners. Expectations follow the stopwatch
// build when CTU60S_TERMINAL_STOP_EN is defined.
module tb_ctu60s;

`ifdef CTU60S_TERMINAL_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, pulse_in, cnt_en, load;
  logic [7:0] load_val;
  logic [7:0] x60, x24, x100;
  logic       c60, c24, c100;
  logic       e60, e24, e100;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctu60s #(.MODULUS(60)) dut60 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .cnt_en(cnt_en), .load(load),
    .load_val(load_val), .x(x60), .carry(c60), .load_err(e60));

  ctu60s #(.MODULUS(24)) dut24 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .cnt_en(cnt_en), .load(load),
    .load_val(load_val), .x(x24), .carry(c24), .load_err(e24));

  ctu60s #(.MODULUS(100)) dut100 (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .cnt_en(cnt_en), .load(load),
    .load_val(load_val), .x(x100), .carry(c100), .load_err(e100));

  typedef struct {
    string      name;
    logic       rst, load, en, pulse;
    logic [7:0] val;
    logic [7:0] ex;
    logic       ec, ee;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic r, logic l, logic e, logic p,
                              logic [7:0] v, logic [7:0] ex, logic ec, logic ee);
    vec_t t;
    t.name = n; t.rst = r; t.load = l; t.en = e; t.pulse = p;
    t.val = v; t.ex = ex; t.ec = ec; t.ee = ee;
    vecs.push_back(t);
  endfunction

  function automatic logic [7:0] bcd(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic l, logic e, logic p, logic [7:0] v);
    rst = r; load = l; cnt_en = e; pulse_in = p; load_val = v;
  endtask

  initial begin
    drive(1, 0, 0, 0, 8'h00);
    step();
    chk("rst_x", x60, 8'h00);
    chk("rst_carry", {7'd0, c60}, 8'h00);
    chk("rst_err", {7'd0, e60}, 8'h00);

    // Full wrap with continuous ticks.
    drive(0, 0, 1, 1, 8'h00);
    for (int i = 1; i <= 60; i++) begin
      int n;
      step();
      n = (STOP && i == 60) ? 59 : (i % 60);
      chk($sformatf("wrap_x_%0d", i), x60, bcd(n));
      chk($sformatf("wrap_c_%0d", i), {7'd0, c60}, {7'd0, (i == 60)});
    end

    add("ld27",      0, 1, 1, 0, 8'h27, 8'h27, 0, 0);
    for (int i = 0; i < 5; i++)
      add("gate",    0, 0, 0, 1, 8'h00, 8'h27, 0, 0);
    add("reen",      0, 0, 1, 1, 8'h00, 8'h28, 0, 0);
    add("ld45p",     0, 1, 1, 1, 8'h45, 8'h45, 0, 0);
    add("ld6A",      0, 1, 1, 0, 8'h6A, 8'h00, 0, 1);
    add("errsticky", 0, 0, 1, 1, 8'h00, 8'h01, 0, 1);
    add("ld60",      0, 1, 1, 0, 8'h60, 8'h00, 0, 1);
    add("ld12",      0, 1, 1, 0, 8'h12, 8'h12, 0, 0);
    add("ld59",      0, 1, 1, 0, 8'h59, 8'h59, 0, 0);
    add("bb1",       0, 0, 1, 1, 8'h00, STOP ? 8'h59 : 8'h00, 1, 0);
    add("bb2",       0, 0, 1, 1, 8'h00, STOP ? 8'h59 : 8'h01, 0, 0);
    add("bb3",       0, 0, 1, 1, 8'h00, STOP ? 8'h59 : 8'h02, 0, 0);
    add("ld59p",     0, 1, 1, 1, 8'h59, 8'h59, 0, 0);
    add("rst59",     1, 0, 1, 1, 8'h00, 8'h00, 0, 0);
    add("tick01",    0, 0, 1, 1, 8'h00, 8'h01, 0, 0);
    add("ldAA",      0, 1, 1, 0, 8'hAA, 8'h00, 0, 1);
    add("rsterr",    1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
    add("ld09",      0, 1, 1, 0, 8'h09, 8'h09, 0, 0);
    add("u09",       0, 0, 1, 1, 8'h00, 8'h10, 0, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].load, vecs[k].en, vecs[k].pulse, vecs[k].val);
      step();
      chk({vecs[k].name, "_x"}, x60, vecs[k].ex);
      chk({vecs[k].name, "_c"}, {7'd0, c60}, {7'd0, vecs[k].ec});
      chk({vecs[k].name, "_e"}, {7'd0, e60}, {7'd0, vecs[k].ee});
    end

    // MODULUS=24: terminal 23.
    drive(1, 0, 0, 0, 8'h00); step();
    drive(0, 1, 1, 0, 8'h22); step();
    chk("m24_ld22", x24, 8'h22);
    drive(0, 0, 1, 1, 8'h00); step();
    chk("m24_23", x24, 8'h23);
    chk("m24_23c", {7'd0, c24}, 8'h00);
    step();
    chk("m24_term", x24, STOP ? 8'h23 : 8'h00);
    chk("m24_termc", {7'd0, c24}, 8'h01);
    step();
    chk("m24_next", x24, STOP ? 8'h23 : 8'h01);
    chk("m24_nextc", {7'd0, c24}, 8'h00);
    step();
    chk("m24_next2", x24, STOP ? 8'h23 : 8'h02);
    chk("m24_next2c", {7'd0, c24}, 8'h00);
    drive(0, 1, 1, 0, 8'h24); step();
    chk("m24_ld24", x24, 8'h00);
    chk("m24_ld24e", {7'd0, e24}, 8'h01);
    drive(0, 1, 1, 1, 8'h23); step();
    chk("m24_ld23", x24, 8'h23);
    chk("m24_ld23e", {7'd0, e24}, 8'h00);
    drive(0, 1, 1, 0, 8'h00); step();
    chk("m24_ld00", x24, 8'h00);
    drive(0, 0, 1, 1, 8'h00); step();
    chk("m24_resume", x24, 8'h01);
    chk("m24_resumec", {7'd0, c24}, 8'h00);

    // MODULUS=100: terminal 99.
    drive(0, 1, 1, 0, 8'h99); step();
    chk("m100_ld99", x100, 8'h99);
    chk("m100_ld99e", {7'd0, e100}, 8'h00);
    drive(0, 0, 1, 1, 8'h00); step();
    chk("m100_wrap", x100, STOP ? 8'h99 : 8'h00);
    chk("m100_wrapc", {7'd0, c100}, 8'h01);
    drive(0, 1, 1, 0, 8'h9F); step();
    chk("m100_ld9F", x100, 8'h00);
    chk("m100_ld9Fe", {7'd0, e100}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
